sram_req_ctrl: RTL and testbench

- Request front-end for the 1R1W 1024x32 byte-masked memory macro wrapper. It sits directly upstream of the macro and drives its W0_*/R0_* pins.
- Accepts independent write and read request channels with valid/ready handshakes.
- Resolves same-address read/write collisions in the issue cycle.
- Absorbs the macro's 1-cycle read latency with a 2-entry response buffer, so the response consumer may backpressure freely.

---
 rtl/sram_req_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sram_req_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: request front-end for a 1R1W byte-masked memory macro.
// Writes pass straight through to the W0_* pins. Reads issue on R0_* under a
// two-credit scheme, and responses are returned strictly in issue order.
// The macro's 1-cycle read latency is absorbed by a bypass path and a 2-entry
// response buffer, so rsp_ready may be held low for any number of cycles.
//
// Ports:
//   clock, reset_n              single clock; async active-low reset
//   wr_valid/wr_ready/wr_*      write request channel (never stalls)
//   rd_valid/rd_ready/rd_addr   read request channel (credit + collision gated)
//   rsp_valid/rsp_ready/rsp_data read response channel
//   W0_*, R0_*                  macro write / read port pins
//
// Optional build macro SRAM_REQ_CTRL_FWD_EN:
//   When it is defined, a same-address read is no longer stalled behind a write.
//   The read issues alongside the write, and the written bytes are merged into
//   the response, which gives write-first data.
//   When it is undefined, a same-address read waits one cycle behind the write.

module sram_req_ctrl #(
  parameter  int ADDR_W    = 10,
  parameter  int DATA_W    = 32,
  localparam int MASK_W    = DATA_W / 8,
  localparam int RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  // write request
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  // read request
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  // read response
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  // macro pins
  output logic              W0_en,
  output logic [ADDR_W-1:0] W0_addr,
  output logic [DATA_W-1:0] W0_data,
  output logic [MASK_W-1:0] W0_mask,
  output logic              R0_en,
  output logic [ADDR_W-1:0] R0_addr,
  input  logic [DATA_W-1:0] R0_data
);

  // run is low throughout reset and for the first edge after it, so that
  // rd_ready comes up as 0 out of reset.
  logic              run;
  logic              inflight;
  logic [1:0]        count;
  logic              wptr;
  logic              rptr;
  logic [DATA_W-1:0] rsp_buf [RSP_DEPTH];

  logic              collision;
  logic              credit;
  logic              issue;
  logic              head_vld;
  logic              push;
  logic              pop;
  logic [1:0]        occupancy;
  logic [DATA_W-1:0] rd_word;

  // ---------------- write path: pure pass-through ----------------
  assign wr_ready = 1'b1;
  assign W0_en    = wr_valid;
  assign W0_addr  = wr_addr;
  assign W0_data  = wr_data;
  assign W0_mask  = wr_mask;

  // ---------------- read issue ----------------
  assign collision = wr_valid & rd_valid & (wr_addr == rd_addr);

  // One credit is held by an outstanding macro read and one by each buffered
  // word. Two credits in total keep the buffer from ever overflowing.
  assign occupancy = count + {1'b0, inflight};
  assign credit    = (occupancy < 2'd2);

`ifdef SRAM_REQ_CTRL_FWD_EN
  assign rd_ready = run & credit;
`else
  // The write wins a same-address collision. The read retries next cycle and
  // then observes the written data.
  assign rd_ready = run & credit & ~collision;
`endif

  assign issue   = rd_valid & rd_ready;
  assign R0_en   = issue;
  assign R0_addr = rd_addr;

  // ---------------- macro read data (optionally merged) ----------------
`ifdef SRAM_REQ_CTRL_FWD_EN
  logic [DATA_W-1:0] fwd_data;
  logic [MASK_W-1:0] fwd_mask;

  // Capture the colliding write alongside the read. A non-colliding read
  // captures an empty mask, so its response is the raw macro data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fwd_data <= '0;
      fwd_mask <= '0;
    end else if (issue) begin
      fwd_data <= wr_data;
      fwd_mask <= collision ? wr_mask : '0;
    end
  end

  always_comb begin
    rd_word = R0_data;
    for (int i = 0; i < MASK_W; i++) begin
      if (fwd_mask[i]) rd_word[8*i +: 8] = fwd_data[8*i +: 8];
    end
  end
`else
  assign rd_word = R0_data;
`endif

  // ---------------- response path ----------------
  // When the buffer is empty, macro data bypasses straight to the output.
  // Otherwise the head of the buffer is presented, which preserves order.
  assign head_vld  = (count != 2'd0);
  assign rsp_valid = head_vld | inflight;
  assign rsp_data  = head_vld ? rsp_buf[rptr] : rd_word;

  // Arriving data is stored when it cannot leave this cycle: either it is
  // queued behind older data, or the bypass is not accepted.
  assign push = inflight & (head_vld | ~rsp_ready);
  assign pop  = head_vld & rsp_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run      <= 1'b0;
      inflight <= 1'b0;
      count    <= 2'd0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= issue;
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count qualifies every entry.
  always_ff @(posedge clock) begin
    if (push) rsp_buf[wptr] <= rd_word;
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
module tb_sram_req_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr_valid, wr_ready;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        rd_valid, rd_ready;
  logic [9:0]  rd_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        W0_en;
  logic [9:0]  W0_addr;
  logic [31:0] W0_data;
  logic [3:0]  W0_mask;
  logic        R0_en;
  logic [9:0]  R0_addr;
  logic [31:0] R0_data;

  always #5 clock = ~clock;

  sram_req_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data), .W0_mask(W0_mask),
    .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(R0_data)
  );

  // Behavioural macro: 1-cycle read latency, read-before-write on collision.
  logic [31:0] mem [0:1023];
  always @(posedge clock) begin
    if (R0_en) R0_data <= mem[R0_addr];
    if (W0_en)
      for (int b = 0; b < 4; b++)
        if (W0_mask[b]) mem[W0_addr][8*b +: 8] <= W0_data[8*b +: 8];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] data;
    int          due;   // cycle the response must appear in, -1 = any
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_rsp(input logic [31:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    exp_q.push_back(e);
  endtask

  // Monitor: each accepted response is compared to the head of the scoreboard.
  always @(negedge clock) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", rsp_data, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        if (e.due >= 0) chk("rsp_cycle", cyc, e.due);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    @(negedge clock);
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_valid = 1'b0; rd_addr = '0; rsp_ready = 1'b0;

    // ---- reset and idle ----
    repeat (3) @(posedge clock);
    settle();
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    tick();
    settle();
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_R0_en", R0_en, 0);
    chk("idle_W0_en", W0_en, 0);
    chk("idle_rd_ready", rd_ready, 1);
    chk("idle_wr_ready", wr_ready, 1);

    // ---- write then read ----
    tick();
    wr_valid = 1'b1; wr_addr = 10'h005; wr_data = 32'hDEADBEEF; wr_mask = 4'hF;
    settle();
    chk("wr_W0_en", W0_en, 1);
    chk("wr_W0_addr", W0_addr, 32'h005);
    chk("wr_W0_data", W0_data, 32'hDEADBEEF);
    chk("wr_W0_mask", W0_mask, 4'hF);
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 10'h005; rsp_ready = 1'b1;
    settle();
    chk("rd_ready", rd_ready, 1);
    chk("rd_R0_en", R0_en, 1);
    chk("rd_R0_addr", R0_addr, 32'h005);
    expect_rsp(32'hDEADBEEF, cyc + 1);
    tick();
    rd_valid = 1'b0;
    settle();
    chk("rd_R0_en_off", R0_en, 0);
    tick();
    drain();

    // ---- backpressure ----
    do_write(10'h001, 32'hA0000001, 4'hF);
    do_write(10'h002, 32'hA0000002, 4'hF);
    do_write(10'h003, 32'hA0000003, 4'hF);
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 10'h001;
    settle();
    chk("bp_rd1_ready", rd_ready, 1);
    expect_rsp(32'hA0000001, -1);
    tick();
    rd_addr = 10'h002;
    settle();
    chk("bp_rd2_ready", rd_ready, 1);
    expect_rsp(32'hA0000002, -1);
    tick();
    rd_addr = 10'h003;
    settle();
    chk("bp_rd3_stall", rd_ready, 0);
    tick();
    settle();
    chk("bp_full_stall", rd_ready, 0);
    chk("bp_full_rsp_valid", rsp_valid, 1);
    tick();
    rsp_ready = 1'b1;
    settle();
    chk("bp_pop_stall", rd_ready, 0);
    tick();
    settle();
    chk("bp_rd3_issue", rd_ready, 1);
    expect_rsp(32'hA0000003, -1);
    tick();
    rd_valid = 1'b0;
    drain();

    // ---- zero-mask write leaves contents unchanged ----
    do_write(10'h020, 32'h55667788, 4'hF);
    wr_valid = 1'b1; wr_addr = 10'h020; wr_data = 32'hFFFFFFFF; wr_mask = 4'h0;
    settle();
    chk("m0_W0_en", W0_en, 1);
    chk("m0_W0_mask", W0_mask, 4'h0);
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 10'h020;
    settle();
    expect_rsp(32'h55667788, cyc + 1);
    tick();
    rd_valid = 1'b0;
    drain();

    // ---- same-address collision ----
    do_write(10'h010, 32'h11223344, 4'hF);
    wr_valid = 1'b1; wr_addr = 10'h010; wr_data = 32'hAABBCCDD; wr_mask = 4'h3;
    rd_valid = 1'b1; rd_addr = 10'h010;
    settle();
`ifdef SRAM_REQ_CTRL_FWD_EN
    chk("col_rd_ready", rd_ready, 1);
    chk("col_R0_en", R0_en, 1);
    expect_rsp(32'h1122CCDD, cyc + 1);
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
`else
    chk("col_rd_ready", rd_ready, 0);
    chk("col_R0_en", R0_en, 0);
    tick();
    wr_valid = 1'b0;
    settle();
    chk("col_retry_ready", rd_ready, 1);
    expect_rsp(32'h1122CCDD, cyc + 1);
    tick();
    rd_valid = 1'b0;
`endif
    drain();

    // ---- reset mid-operation with two buffered responses ----
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 10'h001;
    tick();
    rd_addr = 10'h002;
    tick();
    rd_valid = 1'b0;
    tick();
    settle();
    chk("mid_rsp_valid", rsp_valid, 1);
    chk("mid_full_stall", rd_ready, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rd_ready", rd_ready, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    tick();
    settle();
    chk("post_rst_rd_ready", rd_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    tick();
    rsp_ready = 1'b1;
    rd_valid = 1'b1; rd_addr = 10'h005;
    settle();
    expect_rsp(32'hDEADBEEF, cyc + 1);
    tick();
    rd_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
